// File: rtl/fft_axis_out.sv
// Repackages the pipelined FFT's clock-enabled output stream as an AXI-Stream master with TLAST per frame.
// Optional build macro FFT_AXIS_OUT_TUSER_EN adds M_AXIS_TUSER marking the first bin of each frame.
module fft_axis_out #(
  parameter int unsigned OWIDTH = 21,
  parameter int unsigned LGFFT  = 11,
  parameter int unsigned LGFIFO = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_ce,
  input  logic [2*OWIDTH-1:0] i_sample,
  input  logic                i_sync,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic [2*OWIDTH-1:0] M_AXIS_TDATA,
  output logic                M_AXIS_TLAST,
`ifdef FFT_AXIS_OUT_TUSER_EN
  output logic                M_AXIS_TUSER,
`endif
  output logic                o_overflow,
  output logic                o_sync_err,
  output logic [15:0]         o_drop_count
);

  localparam int unsigned SW    = 2 * OWIDTH;
`ifdef FFT_AXIS_OUT_TUSER_EN
  localparam int unsigned EW    = SW + 2;
`else
  localparam int unsigned EW    = SW + 1;
`endif
  localparam int unsigned DEPTH = 1 << LGFIFO;
  localparam int unsigned PW    = LGFIFO + 1;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    RUN       = 2'd1,
    DROP      = 2'd2
  } state_t;

  state_t            state;
  logic [LGFFT-1:0]  count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [EW-1:0]     mem [DEPTH];

  logic              pop_c;
  logic              full_c;
  logic              wr_ok_c;
  logic              take_c;
  logic              push_c;
  logic              valid_next_c;
  logic [PW-1:0]     rd_next_c;
  logic [LGFFT-1:0]  cnt_eff_c;
  logic              last_c;
  logic [EW-1:0]     entry_c;
  logic [EW-1:0]     rd_data_c;

  // FIFO status and the entry built from the current input sample
  always_comb begin
    pop_c        = M_AXIS_TVALID && M_AXIS_TREADY;
    full_c       = (wr_ptr - rd_ptr) == PW'(DEPTH);
    wr_ok_c      = !full_c || pop_c;
    rd_next_c    = rd_ptr + PW'(pop_c);
    valid_next_c = wr_ptr != rd_next_c;
    take_c       = i_ce && ((state == RUN) || i_sync);
    push_c       = take_c && wr_ok_c;
    cnt_eff_c    = i_sync ? '0 : count;
    last_c       = &cnt_eff_c;
`ifdef FFT_AXIS_OUT_TUSER_EN
    entry_c      = {cnt_eff_c == '0, last_c, i_sample};
`else
    entry_c      = {last_c, i_sample};
`endif
    rd_data_c    = mem[rd_next_c[LGFIFO-1:0]];
  end

  // Sample storage; contents are meaningless outside the pointer window so no reset
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      mem[wr_ptr[LGFIFO-1:0]] <= entry_c;
    end
  end

  // Pointers, registered head-of-FIFO output, frame tracking and status flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= SYNC_WAIT;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TDATA  <= '0;
`ifdef FFT_AXIS_OUT_TUSER_EN
      M_AXIS_TUSER  <= 1'b0;
`endif
      o_overflow    <= 1'b0;
      o_sync_err    <= 1'b0;
      o_drop_count  <= '0;
    end else begin
      rd_ptr <= rd_next_c;
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      // Head register only sees entries written on earlier edges, giving the 2-edge latency
      M_AXIS_TVALID <= valid_next_c;
      M_AXIS_TDATA  <= rd_data_c[SW-1:0];
      M_AXIS_TLAST  <= valid_next_c && rd_data_c[SW];
`ifdef FFT_AXIS_OUT_TUSER_EN
      M_AXIS_TUSER  <= valid_next_c && rd_data_c[SW+1];
`endif

      case (state)
        SYNC_WAIT, DROP: begin
          if (i_ce && i_sync) begin
            count <= LGFFT'(1);
            state <= RUN;
            if (!wr_ok_c) begin
              o_overflow <= 1'b1;
            end
          end
        end
        RUN: begin
          if (i_ce) begin
            if (!wr_ok_c) begin
              o_overflow <= 1'b1;
              state      <= DROP;
              if (o_drop_count != 16'hFFFF) begin
                o_drop_count <= o_drop_count + 16'd1;
              end
            end else begin
              if (i_sync && (count != '0)) begin
                o_sync_err <= 1'b1;
              end
              count <= cnt_eff_c + LGFFT'(1);
            end
          end
        end
        default: begin
          state <= SYNC_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_axis_out.sv
// Directed bench for fft_axis_out with LGFFT=3, LGFIFO=2 and a hand-built queue of expected beats.
module tb_fft_axis_out;

  localparam int unsigned OWIDTH = 8;
  localparam int unsigned LGFFT  = 3;
  localparam int unsigned LGFIFO = 2;
  localparam int unsigned SW     = 2 * OWIDTH;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_ce;
  logic [SW-1:0] i_sample;
  logic          i_sync;
  logic          tvalid;
  logic          tready;
  logic [SW-1:0] tdata;
  logic          tlast;
`ifdef FFT_AXIS_OUT_TUSER_EN
  logic          tuser;
`endif
  logic          o_overflow;
  logic          o_sync_err;
  logic [15:0]   o_drop_count;

  typedef struct {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  fft_axis_out #(.OWIDTH(OWIDTH), .LGFFT(LGFFT), .LGFIFO(LGFIFO)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_ce          (i_ce),
    .i_sample      (i_sample),
    .i_sync        (i_sync),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TLAST  (tlast),
`ifdef FFT_AXIS_OUT_TUSER_EN
    .M_AXIS_TUSER  (tuser),
`endif
    .o_overflow    (o_overflow),
    .o_sync_err    (o_sync_err),
    .o_drop_count  (o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [SW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Present one input cycle; returns 1 time unit after the edge that consumes it
  task automatic cyc(input logic ce, input logic sync, input logic [SW-1:0] d);
    i_ce     = ce;
    i_sync   = sync;
    i_sample = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0);
  endtask

  // Output monitor: scoreboard on each handshake, stability while stalled
  logic          prev_stall = 1'b0;
  logic [SW-1:0] prev_data;
  logic          prev_last;

  always @(negedge i_clk) begin
    if (i_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(tvalid), 32'd1);
        check("hold_data", 32'(tdata), 32'(prev_data));
        check("hold_last", 32'(tlast), 32'(prev_last));
      end
      if (tvalid && tready) begin
        check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("tdata", 32'(tdata), 32'(e.data));
          check("tlast", 32'(tlast), 32'(e.last));
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  initial begin
    i_reset  = 1'b1;
    i_ce     = 1'b0;
    i_sync   = 1'b0;
    i_sample = '0;
    tready   = 1'b1;
    idle(2);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_sync_err", 32'(o_sync_err), 32'd0);
    check("rst_drop_count", 32'(o_drop_count), 32'd0);
    i_reset = 1'b0;

    // Pre-sync samples are discarded, then two back-to-back frames at full rate
    for (int k = 100; k <= 104; k++) cyc(1'b1, 1'b0, SW'(k));
    for (int k = 0; k < 16; k++) push_exp(SW'(k), (k == 7) || (k == 15));
    cyc(1'b1, 1'b1, SW'(0));
    check("latency_edge1", 32'(tvalid), 32'd0);
    cyc(1'b1, 1'b0, SW'(1));
    check("latency_edge2_valid", 32'(tvalid), 32'd1);
    check("latency_edge2_data", 32'(tdata), 32'd0);
    for (int k = 2; k < 16; k++) cyc(1'b1, (k == 8), SW'(k));
    idle(6);
    check("full_rate_drain", 32'(exp_q.size()), 32'd0);
    check("full_rate_overflow", 32'(o_overflow), 32'd0);
    check("full_rate_sync_err", 32'(o_sync_err), 32'd0);
    check("full_rate_drops", 32'(o_drop_count), 32'd0);

    // Stall: four entries fill the FIFO, the fifth is lost and the frame is aborted
    tready = 1'b0;
    for (int k = 20; k <= 23; k++) push_exp(SW'(k), 1'b0);
    for (int k = 20; k <= 29; k++) cyc(1'b1, (k == 20), SW'(k));
    check("ovf_flag", 32'(o_overflow), 32'd1);
    check("ovf_drop_count", 32'(o_drop_count), 32'd1);
    check("ovf_valid_held", 32'(tvalid), 32'd1);
    tready = 1'b1;
    for (int k = 40; k <= 47; k++) push_exp(SW'(k), (k == 47));
    for (int k = 40; k <= 47; k++) cyc(1'b1, (k == 40), SW'(k));
    idle(8);
    check("ovf_drain", 32'(exp_q.size()), 32'd0);
    check("ovf_flag_sticky", 32'(o_overflow), 32'd1);
    check("ovf_drop_count_after", 32'(o_drop_count), 32'd1);

    // Alternating ready with half-rate input; sync/data noise on idle cycles is ignored
    for (int k = 50; k <= 57; k++) push_exp(SW'(k), (k == 57));
    for (int i = 0; i < 16; i++) begin
      tready = (i % 2 == 0);
      if (i % 2 == 1) cyc(1'b1, (i == 1), SW'(50 + i / 2));
      else            cyc(1'b0, 1'b1, SW'(16'h00EE));
    end
    tready = 1'b1;
    idle(6);
    check("toggle_drain", 32'(exp_q.size()), 32'd0);
    check("toggle_drops", 32'(o_drop_count), 32'd1);
    check("toggle_sync_err", 32'(o_sync_err), 32'd0);

    // Sync arriving at count 5 restarts the frame and flags the error
    for (int k = 60; k <= 64; k++) push_exp(SW'(k), 1'b0);
    for (int k = 70; k <= 77; k++) push_exp(SW'(k), (k == 77));
    for (int k = 60; k <= 64; k++) cyc(1'b1, (k == 60), SW'(k));
    for (int k = 70; k <= 77; k++) cyc(1'b1, (k == 70), SW'(k));
    idle(6);
    check("resync_flag", 32'(o_sync_err), 32'd1);
    check("resync_drain", 32'(exp_q.size()), 32'd0);

    // Reset with three entries buffered flushes everything and waits for a new sync
    tready = 1'b0;
    for (int k = 80; k <= 82; k++) cyc(1'b1, (k == 80), SW'(k));
    idle(1);
    check("pre_reset_valid", 32'(tvalid), 32'd1);
    i_reset = 1'b1;
    idle(1);
    exp_q.delete();
    check("mid_reset_tvalid", 32'(tvalid), 32'd0);
    check("mid_reset_overflow", 32'(o_overflow), 32'd0);
    check("mid_reset_sync_err", 32'(o_sync_err), 32'd0);
    check("mid_reset_drops", 32'(o_drop_count), 32'd0);
    i_reset = 1'b0;
    tready  = 1'b1;
    for (int k = 91; k <= 98; k++) push_exp(SW'(k), (k == 98));
    cyc(1'b1, 1'b0, SW'(90));
    for (int k = 91; k <= 98; k++) cyc(1'b1, (k == 91), SW'(k));
    idle(6);
    check("post_reset_drain", 32'(exp_q.size()), 32'd0);
    check("post_reset_overflow", 32'(o_overflow), 32'd0);
    check("post_reset_sync_err", 32'(o_sync_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
